// File: rtl/basket_receipt_tx.sv
// Receipt frame transmitter: serialises a header, the basket entries, the total and an XOR
// checksum as back-to-back UART 8N1 bytes, fetching each entry one byte ahead of use.
module basket_receipt_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_ITEMS    = 12
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        START,
    input  logic [3:0]  NUM,
    input  logic [15:0] T_PRICE,
    output logic [3:0]  RD_IDX,
    input  logic [3:0]  RD_ID,
    input  logic [3:0]  RD_QTT,
    input  logic [15:0] RD_PRICE,
    output logic        TX,
    output logic        BUSY,
    output logic        DONE
);
    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    MAX_N    = 4'(MAX_ITEMS);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_CNT, S_ITEM, S_TOT_HI, S_TOT_LO, S_CHK} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_clk_cnt;
    logic [3:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_chk;
    logic [3:0]      r_n;
    logic [15:0]     r_tot;
    logic [3:0]      r_k;
    logic [1:0]      r_sub;
    logic [3:0]      r_id;
    logic [3:0]      r_qtt;
    logic [15:0]     r_price;
    logic            r_fetch;
    logic [3:0]      r_rd_idx;
    logic            r_done;

    logic            w_accept;
    logic            w_bit_end;
    logic            w_byte_end;
    logic            w_last_item;
    logic [7:0]      w_next_byte;

    assign w_accept    = (r_state == S_IDLE) && START;
    assign w_bit_end   = (r_state != S_IDLE) && (r_clk_cnt == LAST_CLK);
    assign w_byte_end  = w_bit_end && (r_bit_idx == 4'd9);
    assign w_last_item = (r_k == r_n - 4'd1);

    always_ff @(posedge CLOCK_50) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // w_next_byte is the byte that follows the one currently on the line.
    always_comb begin
        w_next      = r_state;
        w_next_byte = 8'h00;
        case (r_state)
            S_IDLE: begin
                w_next_byte = 8'hA5;
                if (START) w_next = S_HDR;
            end
            S_HDR: begin
                w_next_byte = {4'h0, r_n};
                if (w_byte_end) w_next = S_CNT;
            end
            S_CNT: begin
                w_next_byte = (r_n != 4'd0) ? {4'h0, r_id} : r_tot[15:8];
                if (w_byte_end) w_next = (r_n != 4'd0) ? S_ITEM : S_TOT_HI;
            end
            S_ITEM: begin
                case (r_sub)
                    2'd0:    w_next_byte = {4'h0, r_qtt};
                    2'd1:    w_next_byte = r_price[15:8];
                    2'd2:    w_next_byte = r_price[7:0];
                    default: w_next_byte = w_last_item ? r_tot[15:8] : {4'h0, r_id};
                endcase
                if (w_byte_end && r_sub == 2'd3 && w_last_item) w_next = S_TOT_HI;
            end
            S_TOT_HI: begin
                w_next_byte = r_tot[7:0];
                if (w_byte_end) w_next = S_TOT_LO;
            end
            S_TOT_LO: begin
                w_next_byte = r_chk;
                if (w_byte_end) w_next = S_CHK;
            end
            S_CHK: begin
                if (w_byte_end) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_clk_cnt <= '0;
            r_bit_idx <= 4'd0;
            r_shift   <= 8'h00;
            r_chk     <= 8'h00;
            r_n       <= 4'd0;
            r_tot     <= 16'h0000;
            r_k       <= 4'd0;
            r_sub     <= 2'd0;
            r_id      <= 4'd0;
            r_qtt     <= 4'd0;
            r_price   <= 16'h0000;
            r_fetch   <= 1'b0;
            r_rd_idx  <= 4'd0;
            r_done    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_fetch <= 1'b0;
            if (r_fetch) begin
                r_id    <= RD_ID;
                r_qtt   <= RD_QTT;
                r_price <= RD_PRICE;
            end
            if (w_accept) begin
                r_n       <= (NUM > MAX_N) ? MAX_N : NUM;
                r_tot     <= T_PRICE;
                r_shift   <= 8'hA5;
                r_chk     <= 8'hA5;
                r_clk_cnt <= '0;
                r_bit_idx <= 4'd0;
                r_k       <= 4'd0;
                r_sub     <= 2'd0;
                r_rd_idx  <= 4'd0;
                r_fetch   <= 1'b1;
            end else if (w_bit_end) begin
                r_clk_cnt <= '0;
                if (r_bit_idx == 4'd9) begin
                    r_bit_idx <= 4'd0;
                    r_shift   <= w_next_byte;
                    r_chk     <= r_chk ^ w_next_byte;
                    if (r_state == S_CHK) r_done <= 1'b1;
                    if (r_state == S_ITEM) begin
                        r_sub <= r_sub + 2'd1;
                        // Once the price low byte is loaded the entry registers are free,
                        // so the next entry is fetched a whole byte time before it is needed.
                        if (r_sub == 2'd2) begin
                            r_rd_idx <= w_last_item ? 4'd0 : r_k + 4'd1;
                            r_fetch  <= !w_last_item;
                        end
                        if (r_sub == 2'd3 && !w_last_item) r_k <= r_k + 4'd1;
                    end
                end else begin
                    r_bit_idx <= r_bit_idx + 4'd1;
                    if (r_bit_idx != 4'd0) r_shift <= {1'b0, r_shift[7:1]};
                end
            end else if (r_state != S_IDLE) begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        TX = 1'b1;
        if (r_state != S_IDLE) begin
            if (r_bit_idx == 4'd0)      TX = 1'b0;
            else if (r_bit_idx != 4'd9) TX = r_shift[0];
        end
    end

    assign BUSY   = (r_state != S_IDLE);
    assign DONE   = r_done;
    assign RD_IDX = r_rd_idx;

endmodule
